// File: rtl/overdrive_mc.sv
// overdrive_mc: multi-channel overdrive stage.
// Stage 1 applies the smoothed per-channel gain, stage 2 clamps/saturates
// according to the latched mode, and stage 3 applies the soft-clip
// polynomial and drives the registered outputs. A single global stall
// holds every stage while the output register waits on out_ready.
module overdrive_mc #(
    parameter int WIDTH      = 16,
    parameter int GAIN_FRAC  = 4,
    parameter int LEVEL_BITS = 12,
    parameter int CHANNELS   = 2,
    parameter int RAMP_SHIFT = 2,
    localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_sample,
    input  logic [CW-1:0]           in_channel,
    input  logic signed [WIDTH-1:0] gain_target,
    input  logic [1:0]              mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_sample,
    output logic [CW-1:0]           out_channel,
    output logic                    out_clip
);

    localparam int PW = 2 * WIDTH;                  // full product width
    localparam int DW = WIDTH + 1;                  // gain difference width
    localparam int XW = 3 * (LEVEL_BITS + 1) + 1;   // soft-clip cube width

    localparam logic signed [WIDTH-1:0] UNITY  = WIDTH'(2 ** GAIN_FRAC);
    localparam logic signed [PW-1:0]    LIM_P  = PW'(2 ** LEVEL_BITS);
    localparam logic signed [PW-1:0]    LIM_N  = -LIM_P;
    localparam logic signed [PW-1:0]    ASYM_N = -(LIM_P >>> 1);
    localparam logic signed [PW-1:0]    SAT_P  = PW'(2 ** (WIDTH - 1) - 1);
    localparam logic signed [PW-1:0]    SAT_N  = ~SAT_P;
    localparam logic signed [DW-1:0]    D_ZERO = {DW{1'b0}};
    localparam logic signed [DW-1:0]    D_ONE  = {{(DW-1){1'b0}}, 1'b1};
    localparam logic signed [DW-1:0]    D_MONE = {DW{1'b1}};

    // Clamp p into [lo, hi]; returns {clip, clamped value}.
    function automatic logic [WIDTH:0] clamp_f(
        input logic signed [PW-1:0] p,
        input logic signed [PW-1:0] lo,
        input logic signed [PW-1:0] hi
    );
        logic signed [PW-1:0] v;
        logic                 c;
        if (p > hi) begin
            v = hi;
            c = 1'b1;
        end else if (p < lo) begin
            v = lo;
            c = 1'b1;
        end else begin
            v = p;
            c = 1'b0;
        end
        return {c, v[WIDTH-1:0]};
    endfunction

    logic signed [WIDTH-1:0] gain_cur_r [CHANNELS];
    logic                    advance_s, accept_s, ch_ok_s;
    logic signed [WIDTH-1:0] gain_sel_s, gain_next_s;
    logic signed [DW-1:0]    diff_s, step_s;
    logic signed [PW-1:0]    prod_s;

    logic                    s1_valid_r;
    logic signed [PW-1:0]    s1_prod_r;
    logic [CW-1:0]           s1_ch_r;
    logic [1:0]              s1_mode_r;

    logic [WIDTH:0]          s2_shape_s;
    logic                    s2_valid_r, s2_clip_r;
    logic signed [WIDTH-1:0] s2_val_r;
    logic [CW-1:0]           s2_ch_r;
    logic [1:0]              s2_mode_r;

    logic signed [XW-1:0]    x_s, cube_s, tri_s;
    logic signed [WIDTH-1:0] shaped_s;

    assign advance_s = !out_valid || out_ready;
    assign in_ready  = advance_s;
    assign accept_s  = in_valid && advance_s;

    // Select the gain for the incoming channel; unknown channels use unity.
    always_comb begin
        gain_sel_s = UNITY;
        ch_ok_s    = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            gain_sel_s = (in_channel == CW'(c)) ? gain_cur_r[c] : gain_sel_s;
            ch_ok_s    = ch_ok_s | (in_channel == CW'(c));
        end
    end

    // Ramp step toward the target: a fraction of the gap, never zero while a gap remains.
    always_comb begin
        diff_s = DW'(gain_target) - DW'(gain_sel_s);
        if ((diff_s != D_ZERO) && ((diff_s >>> RAMP_SHIFT) == D_ZERO)) begin
            step_s = diff_s[DW-1] ? D_MONE : D_ONE;
        end else begin
            step_s = diff_s >>> RAMP_SHIFT;
        end
        gain_next_s = WIDTH'(DW'(gain_sel_s) + step_s);
        prod_s      = PW'(in_sample) * PW'(gain_sel_s);
    end

    // Per-channel smoothed gain, stepped once per accepted sample of that channel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) gain_cur_r[c] <= UNITY;
        end else if (accept_s && ch_ok_s) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (in_channel == CW'(c)) gain_cur_r[c] <= gain_next_s;
            end
        end
    end

    // Mode-dependent clamp/saturation of the gained sample.
    always_comb begin
        case (s1_mode_r)
            2'd0:    s2_shape_s = clamp_f(s1_prod_r, SAT_N, SAT_P);
            2'd1:    s2_shape_s = clamp_f(s1_prod_r, LIM_N, LIM_P);
            2'd2:    s2_shape_s = clamp_f(s1_prod_r, LIM_N, LIM_P);
            2'd3:    s2_shape_s = clamp_f(s1_prod_r, ASYM_N, LIM_P);
            default: s2_shape_s = clamp_f(s1_prod_r, SAT_N, SAT_P);
        endcase
    end

    // Soft-clip cubic y = 1.5x - x^3/(2L^2); other modes pass the clamped value.
    always_comb begin
        x_s    = XW'(s2_val_r);
        cube_s = x_s * x_s * x_s;
        tri_s  = (x_s + (x_s <<< 1)) >>> 1;
        if (s2_mode_r == 2'd2) begin
            shaped_s = WIDTH'(tri_s - (cube_s >>> (2 * LEVEL_BITS + 1)));
        end else begin
            shaped_s = s2_val_r;
        end
    end

    // Three-stage pipeline with global stall; data registers load only with valid data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_r  <= 1'b0;
            s1_prod_r   <= {PW{1'b0}};
            s1_ch_r     <= {CW{1'b0}};
            s1_mode_r   <= 2'd0;
            s2_valid_r  <= 1'b0;
            s2_val_r    <= {WIDTH{1'b0}};
            s2_clip_r   <= 1'b0;
            s2_ch_r     <= {CW{1'b0}};
            s2_mode_r   <= 2'd0;
            out_valid   <= 1'b0;
            out_sample  <= {WIDTH{1'b0}};
            out_channel <= {CW{1'b0}};
            out_clip    <= 1'b0;
        end else if (advance_s) begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_prod_r <= prod_s >>> GAIN_FRAC;
                s1_ch_r   <= in_channel;
                s1_mode_r <= mode;
            end
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_val_r  <= s2_shape_s[WIDTH-1:0];
                s2_clip_r <= s2_shape_s[WIDTH];
                s2_ch_r   <= s1_ch_r;
                s2_mode_r <= s1_mode_r;
            end
            out_valid <= s2_valid_r;
            if (s2_valid_r) begin
                out_sample  <= shaped_s;
                out_channel <= s2_ch_r;
                out_clip    <= s2_clip_r;
            end
        end
    end

endmodule

// File: tb/tb_overdrive_mc.sv
// Testbench for overdrive_mc: scoreboard fed by an arithmetic reference model,
// separate monitor process checking every output transfer.
module tb_overdrive_mc;

    localparam int CH = 2;

    typedef struct {
        int sample;
        int ch;
        bit clip;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] in_sample = 16'sd0;
    logic [0:0]         in_channel = 1'b0;
    logic signed [15:0] gain_target = 16'sd16;
    logic [1:0]         mode = 2'd0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [15:0] out_sample;
    logic [0:0]         out_channel;
    logic               out_clip;

    exp_t sb_q[$];
    int   gain_m[CH];
    int   n_checks = 0;
    int   n_pass = 0;
    int   ready_mode = 0;

    overdrive_mc dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sample(in_sample), .in_channel(in_channel),
        .gain_target(gain_target), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sample(out_sample), .out_channel(out_channel), .out_clip(out_clip)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic longint fdiv(input longint a, input longint b);
        longint q = a / b;
        if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
        return q;
    endfunction

    // Reference model: expected result of one accepted sample, and gain ramp update.
    function automatic exp_t model(input int s, input int ch, input int tgt, input int m);
        exp_t   e;
        longint p, lo, hi, x;
        int     g, d, st;
        g = (ch < CH) ? gain_m[ch] : 16;
        p = fdiv(longint'(s) * longint'(g), 16);
        lo = -32768;
        hi = 32767;
        if (m == 1 || m == 2) begin
            lo = -4096;
            hi = 4096;
        end else if (m == 3) begin
            lo = -2048;
            hi = 4096;
        end
        x = (p < lo) ? lo : ((p > hi) ? hi : p);
        e.clip = (p < lo) || (p > hi);
        if (m == 2) x = fdiv(3 * x, 2) - fdiv(x * x * x, longint'(1) << 25);
        e.sample = int'(x);
        e.ch = ch;
        if (ch < CH) begin
            d = tgt - g;
            st = int'(fdiv(longint'(d), 4));
            if (d != 0 && st == 0) st = (d > 0) ? 1 : -1;
            gain_m[ch] = g + st;
        end
        return e;
    endfunction

    task automatic reset_model();
        sb_q.delete();
        for (int c = 0; c < CH; c++) gain_m[c] = 16;
    endtask

    // Present one sample (leaves in_valid high so calls chain back-to-back).
    task automatic send(input int s, input int ch, input int tgt, input int m);
        bit done = 1'b0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            in_valid    = 1'b1;
            in_sample   = 16'(s);
            in_channel  = 1'(ch);
            gain_target = 16'(tgt);
            mode        = 2'(m);
            #1;
            if (in_ready) begin
                sb_q.push_back(model(s, ch, tgt, m));
                done = 1'b1;
            end
        end
        if (!done) begin
            n_checks++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1");
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: pending %0d, expected 0", sb_q.size());
        end
    endtask

    // Downstream ready pattern, changed mid-way through the high clock phase.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pop and compare on each transfer; check held outputs during stalls.
    initial begin
        exp_t               e;
        bit                 hold = 1'b0;
        logic signed [15:0] hs;
        logic [0:0]         hch;
        logic               hcl;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("hold_valid", longint'(out_valid), 1);
                    chk("hold_sample", longint'(out_sample), longint'(hs));
                    chk("hold_channel", longint'(out_channel), longint'(hch));
                    chk("hold_clip", longint'(out_clip), longint'(hcl));
                end
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_output: sample %0d ch %0d, expected none",
                                 out_sample, out_channel);
                    end else begin
                        e = sb_q.pop_front();
                        chk("out_sample", longint'(out_sample), longint'(e.sample));
                        chk("out_channel", longint'(out_channel), longint'(e.ch));
                        chk("out_clip", longint'(out_clip), longint'(e.clip));
                    end
                end
                hold = out_valid && !out_ready;
                hs   = out_sample;
                hch  = out_channel;
                hcl  = out_clip;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_model();
        repeat (3) @(negedge clk);
        #3;
        chk("reset_out_valid", longint'(out_valid), 0);
        chk("reset_out_sample", longint'(out_sample), 0);
        chk("reset_out_channel", longint'(out_channel), 0);
        chk("reset_out_clip", longint'(out_clip), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_in_ready", longint'(in_ready), 1);

        // Passthrough and exact latency
        send(1000, 0, 16, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #3;
        chk("lat_c1_valid", longint'(out_valid), 0);
        chk("lat_c1_sample", longint'(out_sample), 0);
        @(negedge clk);
        #3;
        chk("lat_c2_valid", longint'(out_valid), 0);
        chk("lat_c2_sample", longint'(out_sample), 0);
        @(negedge clk);
        #3;
        chk("lat_c3_valid", longint'(out_valid), 1);
        chk("lat_c3_sample", longint'(out_sample), 1000);
        chk("lat_c3_clip", longint'(out_clip), 0);
        drain();

        // Hard and asymmetric clip
        send(5000, 0, 16, 1);
        send(-5000, 0, 16, 1);
        send(-5000, 0, 16, 3);
        send(3000, 0, 16, 3);
        // Soft clip
        send(2048, 0, 16, 2);
        send(4096, 0, 16, 2);
        send(8000, 0, 16, 2);
        send(-2048, 0, 16, 2);
        idle();
        drain();

        // Gain ramp on ch0 interleaved with steady ch1
        for (int i = 0; i < 6; i++) begin
            send(100, 0, 32, 0);
            send(100, 1, 16, 0);
        end
        idle();
        drain();

        // Backpressure: 6 back-to-back samples, out_ready low for 5 cycles
        fork
            begin
                for (int i = 0; i < 6; i++) send(700 + 300 * i, i % 2, 48 - 8 * i, 1);
                idle();
            end
            begin
                repeat (4) @(negedge clk);
                ready_mode = 2;
                repeat (5) begin
                    @(negedge clk);
                    #1;
                    chk("bp_in_ready", longint'(in_ready), 0);
                end
                ready_mode = 0;
            end
        join
        drain();

        // Reset with three samples in flight
        send(1234, 0, 40, 1);
        send(-777, 1, 8, 2);
        send(2222, 0, 40, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        reset_model();
        @(negedge clk);
        #3;
        chk("midrst_out_valid", longint'(out_valid), 0);
        chk("midrst_out_sample", longint'(out_sample), 0);
        rst_n = 1'b1;
        send(100, 0, 16, 1);
        idle();
        drain();

        // Randomized traffic with random downstream backpressure
        ready_mode = 1;
        for (int i = 0; i < 300; i++) begin
            send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 80)) - 20, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 7) == 0) idle();
        end
        idle();
        ready_mode = 0;
        drain();
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
